// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave shifter: FSM state encoding and
// the bit-counter width function.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2
  } spi_state_e;

  // One extra bit so the counter can represent DATA_W itself.
  function automatic int unsigned bit_cnt_w(input int unsigned data_w);
    return $clog2(data_w) + 1;
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Received-bit counter for the SPI slave: counts sampled bits, flags the bit
// that completes a frame, and clears whenever chip select is inactive.
module spi_bit_counter
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = bit_cnt_w(DATA_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cs_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // The sample that would take the count to DATA_W closes the frame, so the
  // counter wraps straight to zero instead of ever holding DATA_W.
  assign o_done    = i_inc && (r_cnt == CNT_W'(DATA_W - 1));
  assign o_bit_cnt = r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_cs_n || o_done) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI slave shift engine behind an SCLK edge-detect stage, with a one-word TX
// holding register. Optional overrun detection: SPI_SLAVE_OVR_DET_EN.
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CPHA      = 1,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef SPI_SLAVE_OVR_DET_EN
  input  logic              rx_ack,
`endif
  input  logic              cs_n,
  input  logic              sampl_en,
  input  logic              shift_en,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_ovr
);

  localparam int unsigned CNT_W = bit_cnt_w(DATA_W);

  spi_state_e        r_state, w_state_nxt;
  logic [DATA_W-1:0] r_hold, r_tx_shreg, r_rx_shreg, r_rx_data;
  logic [DATA_W-1:0] w_rx_next, w_tx_next;
  logic              r_full, r_tx_ready, r_rx_valid, r_miso_oe;
  logic              w_sample, w_shift, w_load, w_advance, w_accept, w_full_nxt;
  logic              w_frame_done, w_cnt_zero;
  logic [CNT_W-1:0]  w_bit_cnt;

  spi_bit_counter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_cs_n    (cs_n),
    .i_inc     (w_sample),
    .o_bit_cnt (w_bit_cnt),
    .o_done    (w_frame_done)
  );

  // A sample wins over a coincident shift request.
  assign w_sample   = !cs_n && sampl_en && (r_state == SHIFT);
  assign w_shift    = !cs_n && shift_en && !sampl_en;
  assign w_cnt_zero = (w_bit_cnt == '0);

  // A shift with no bits yet sampled in the current frame is the frame's first
  // edge: CPHA=1 loads on it, CPHA=0 (already loaded) ignores it.
  assign w_load    = (CPHA == 0) ? ((r_state == ARM && !cs_n) || w_frame_done)
                                 : (w_shift && w_cnt_zero && (r_state != IDLE));
  assign w_advance = w_shift && !w_cnt_zero && (r_state == SHIFT);

  // A frame load frees the holding register in the same cycle, so a
  // coincident tx_valid is taken even though tx_ready reads 0.
  assign w_accept   = tx_valid && (r_tx_ready || w_load);
  assign w_full_nxt = w_accept ? 1'b1 : (w_load ? 1'b0 : r_full);

  assign w_rx_next = (MSB_FIRST != 0) ? {r_rx_shreg[DATA_W-2:0], mosi}
                                      : {mosi, r_rx_shreg[DATA_W-1:1]};
  assign w_tx_next = (MSB_FIRST != 0) ? {r_tx_shreg[DATA_W-2:0], 1'b0}
                                      : {1'b0, r_tx_shreg[DATA_W-1:1]};

  // NOTE: assign every always_comb output a default first so no path through
  // the block leaves it unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!cs_n) w_state_nxt = ARM;
      ARM:     if (CPHA == 0 || w_shift) w_state_nxt = SHIFT;
      SHIFT:   w_state_nxt = SHIFT;
      default: w_state_nxt = IDLE;
    endcase
    if (cs_n) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_hold     <= '0;
      r_full     <= 1'b0;
      r_tx_ready <= 1'b0;
      r_tx_shreg <= '0;
      r_rx_shreg <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_miso_oe  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_full     <= w_full_nxt;
      r_tx_ready <= !w_full_nxt;
      r_rx_valid <= w_frame_done;
      r_miso_oe  <= !cs_n;
      if (w_accept)     r_hold     <= tx_data;
      if (w_load)       r_tx_shreg <= r_full ? r_hold : '0;
      else if (w_advance) r_tx_shreg <= w_tx_next;
      if (w_sample)     r_rx_shreg <= w_rx_next;
      if (w_frame_done) r_rx_data  <= w_rx_next;
    end
  end

  assign miso     = r_miso_oe && ((MSB_FIRST != 0) ? r_tx_shreg[DATA_W-1] : r_tx_shreg[0]);
  assign miso_oe  = r_miso_oe;
  assign tx_ready = r_tx_ready;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

`ifdef SPI_SLAVE_OVR_DET_EN
  // r_rx_pend marks a delivered word that has not yet been acknowledged.
  logic r_rx_pend, r_rx_ovr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_pend <= 1'b0;
      r_rx_ovr  <= 1'b0;
    end else begin
      if (w_frame_done)  r_rx_pend <= 1'b1;
      else if (rx_ack)   r_rx_pend <= 1'b0;
      if (w_frame_done && r_rx_pend && !rx_ack) r_rx_ovr <= 1'b1;
      else if (rx_ack)                          r_rx_ovr <= 1'b0;
    end
  end

  assign rx_ovr = r_rx_ovr;
`else
  assign rx_ovr = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Bench for spi_slave_shifter: instance 0 runs CPHA=0, instance 1 CPHA=1,
// both MSB first; received words are checked through a per-instance queue.
module tb_spi_slave_shifter;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   cs_n = 2'b11, sampl_en = 2'b00, shift_en = 2'b00;
  logic [1:0]   mosi = 2'b00, tx_valid = 2'b00;
`ifdef SPI_SLAVE_OVR_DET_EN
  logic [1:0]   rx_ack = 2'b00;
`endif
  logic [W-1:0] tx_data0 = '0, tx_data1 = '0;
  wire  [1:0]   miso, miso_oe, tx_ready, rx_valid, rx_ovr;
  wire  [W-1:0] rx_data0, rx_data1;

  int           n_vec = 0;
  int           n_err = 0;
  int           rv_cnt [2] = '{0, 0};
  logic [W-1:0] m_hold [2] = '{8'h00, 8'h00};
  bit           m_full [2] = '{1'b0, 1'b0};
  logic [W-1:0] exp_rx0[$];
  logic [W-1:0] exp_rx1[$];
  logic [W-1:0] e0, e1;

  always #5 clk = ~clk;

  spi_slave_shifter #(.DATA_W(W), .CPHA(0), .MSB_FIRST(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
`ifdef SPI_SLAVE_OVR_DET_EN
    .rx_ack(rx_ack[0]),
`endif
    .cs_n(cs_n[0]), .sampl_en(sampl_en[0]), .shift_en(shift_en[0]), .mosi(mosi[0]),
    .miso(miso[0]), .miso_oe(miso_oe[0]), .tx_data(tx_data0), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .rx_data(rx_data0), .rx_valid(rx_valid[0]), .rx_ovr(rx_ovr[0])
  );

  spi_slave_shifter #(.DATA_W(W), .CPHA(1), .MSB_FIRST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef SPI_SLAVE_OVR_DET_EN
    .rx_ack(rx_ack[1]),
`endif
    .cs_n(cs_n[1]), .sampl_en(sampl_en[1]), .shift_en(shift_en[1]), .mosi(mosi[1]),
    .miso(miso[1]), .miso_oe(miso_oe[1]), .tx_data(tx_data1), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .rx_data(rx_data1), .rx_valid(rx_valid[1]), .rx_ovr(rx_ovr[1])
  );

  // Scoreboard side: every rx_valid pops the oldest expected word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid[0]) begin
        rv_cnt[0]++;
        n_vec++;
        if (exp_rx0.size() == 0) begin
          n_err++;
          $display("FAIL rx_unexpected p0: rx_data=%h with nothing expected", rx_data0);
        end else begin
          e0 = exp_rx0.pop_front();
          if (rx_data0 !== e0) begin
            n_err++;
            $display("FAIL rx_data p0: got %h expected %h", rx_data0, e0);
          end
        end
      end
      if (rx_valid[1]) begin
        rv_cnt[1]++;
        n_vec++;
        if (exp_rx1.size() == 0) begin
          n_err++;
          $display("FAIL rx_unexpected p1: rx_data=%h with nothing expected", rx_data1);
        end else begin
          e1 = exp_rx1.pop_front();
          if (rx_data1 !== e1) begin
            n_err++;
            $display("FAIL rx_data p1: got %h expected %h", rx_data1, e1);
          end
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic pulse(input int p, input bit sh, input bit sa, input bit m);
    @(negedge clk);
    shift_en[p] = sh;
    sampl_en[p] = sa;
    mosi[p]     = m;
    @(negedge clk);
    shift_en[p] = 1'b0;
    sampl_en[p] = 1'b0;
  endtask

  task automatic load_tx(input int p, input logic [W-1:0] w);
    @(negedge clk);
    n_vec++;
    if (tx_ready[p] !== 1'b1) begin
      n_err++;
      $display("FAIL tx_ready_idle p%0d: got %b expected 1", p, tx_ready[p]);
    end
    tx_valid[p] = 1'b1;
    if (p == 0) tx_data0 = w; else tx_data1 = w;
    @(negedge clk);
    tx_valid[p] = 1'b0;
    n_vec++;
    if (tx_ready[p] !== 1'b0) begin
      n_err++;
      $display("FAIL tx_ready_full p%0d: got %b expected 0", p, tx_ready[p]);
    end
    m_hold[p] = w;
    m_full[p] = 1'b1;
  endtask

  task automatic start(input int p);
    @(negedge clk);
    cs_n[p] = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (miso_oe[p] !== 1'b1) begin
      n_err++;
      $display("FAIL miso_oe_on p%0d: got %b expected 1", p, miso_oe[p]);
    end
  endtask

  task automatic stop(input int p);
    @(negedge clk);
    cs_n[p] = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (miso_oe[p] !== 1'b0 || miso[p] !== 1'b0) begin
      n_err++;
      $display("FAIL miso_off p%0d: oe=%b miso=%b expected 0/0", p, miso_oe[p], miso[p]);
    end
  endtask

  // One frame as the master sees it; nbits < W models an aborted frame.
  task automatic run_frame(input int p, input logic [W-1:0] rx_word, input int nbits,
                           input bit do_refill, input logic [W-1:0] refill_word);
    logic [W-1:0] txw;
    txw       = m_full[p] ? m_hold[p] : '0;
    m_full[p] = 1'b0;
    if (nbits == W) begin
      if (p == 0) exp_rx0.push_back(rx_word); else exp_rx1.push_back(rx_word);
    end
    for (int i = 0; i < nbits; i++) begin
      if (p == 1 || i > 0) pulse(p, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (miso[p] !== txw[W-1-i]) begin
        n_err++;
        $display("FAIL miso_bit p%0d bit%0d: got %b expected %b (word %h)", p, i, miso[p], txw[W-1-i], txw);
      end
      pulse(p, 1'b0, 1'b1, rx_word[W-1-i]);
      if (nbits == W && i == W - 1) begin
        n_vec++;
        if (rx_valid[p] !== 1'b1) begin
          n_err++;
          $display("FAIL rx_valid_latency p%0d: got %b expected 1", p, rx_valid[p]);
        end
      end
      if (do_refill && i == 3) load_tx(p, refill_word);
    end
    if (nbits == W && p == 0) pulse(p, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      n_vec++;
      if ({miso[p], miso_oe[p], tx_ready[p], rx_valid[p], rx_ovr[p]} !== 5'b0) begin
        n_err++;
        $display("FAIL reset_flags p%0d: miso/oe/rdy/rv/ovr=%b expected 00000", p,
                 {miso[p], miso_oe[p], tx_ready[p], rx_valid[p], rx_ovr[p]});
      end
    end
    n_vec++;
    if (rx_data0 !== '0 || rx_data1 !== '0) begin
      n_err++;
      $display("FAIL reset_rx_data: got %h/%h expected 00/00", rx_data0, rx_data1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (tx_ready !== 2'b11) begin
      n_err++;
      $display("FAIL tx_ready_after_reset: got %b expected 11", tx_ready);
    end
  endtask

  task automatic test_cpha1_basic();
    int c;
    c = rv_cnt[1];
    load_tx(1, 8'hA5);
    start(1);
    run_frame(1, 8'h3C, W, 1'b0, 8'h00);
    stop(1);
    n_vec++;
    if (rv_cnt[1] - c != 1) begin
      n_err++;
      $display("FAIL cpha1_pulses: got %0d expected 1", rv_cnt[1] - c);
    end
  endtask

  task automatic test_cpha0_basic();
    int c;
    c = rv_cnt[0];
    load_tx(0, 8'h81);
    start(0);
    run_frame(0, 8'hD2, W, 1'b0, 8'h00);
    stop(0);
    n_vec++;
    if (rv_cnt[0] - c != 1) begin
      n_err++;
      $display("FAIL cpha0_pulses: got %0d expected 1", rv_cnt[0] - c);
    end
  endtask

  task automatic test_back_to_back(input int p);
    int c;
    c = rv_cnt[p];
    load_tx(p, 8'h4B);
    start(p);
    run_frame(p, 8'hE7, W, 1'b1, 8'hB6);
    run_frame(p, 8'h18, W, 1'b0, 8'h00);
    stop(p);
    n_vec++;
    if (rv_cnt[p] - c != 2) begin
      n_err++;
      $display("FAIL b2b_pulses p%0d: got %0d expected 2", p, rv_cnt[p] - c);
    end
  endtask

  task automatic test_abort(input int p);
    int c;
    logic [3:0] cnt;
    c = rv_cnt[p];
    load_tx(p, 8'h33);
    start(p);
    run_frame(p, 8'hFF, 5, 1'b1, 8'h96);
    stop(p);
    cnt = (p == 0) ? u_dut0.w_bit_cnt : u_dut1.w_bit_cnt;
    n_vec++;
    if (cnt !== 4'd0 || rv_cnt[p] != c) begin
      n_err++;
      $display("FAIL abort p%0d: bit_cnt=%0d pulses=%0d expected 0/0", p, cnt, rv_cnt[p] - c);
    end
    start(p);
    run_frame(p, 8'h69, W, 1'b0, 8'h00);
    stop(p);
    n_vec++;
    if (rv_cnt[p] - c != 1) begin
      n_err++;
      $display("FAIL abort_recover p%0d: pulses=%0d expected 1", p, rv_cnt[p] - c);
    end
  endtask

  task automatic test_empty_hold();
    start(1);
    run_frame(1, 8'h5C, W, 1'b0, 8'h00);
    n_vec++;
    if (tx_ready[1] !== 1'b1) begin
      n_err++;
      $display("FAIL empty_hold_ready: got %b expected 1", tx_ready[1]);
    end
    stop(1);
  endtask

  task automatic test_collision();
    load_tx(1, 8'hC3);
    start(1);
    @(negedge clk);
    shift_en[1] = 1'b1;
    tx_valid[1] = 1'b1;
    tx_data1    = 8'h5A;
    @(negedge clk);
    shift_en[1] = 1'b0;
    tx_valid[1] = 1'b0;
    n_vec++;
    if (tx_ready[1] !== 1'b0 || miso[1] !== 1'b1) begin
      n_err++;
      $display("FAIL collision: tx_ready=%b miso=%b expected 0/1", tx_ready[1], miso[1]);
    end
    m_hold[1] = 8'h5A;
    m_full[1] = 1'b1;
    stop(1);
    start(1);
    run_frame(1, 8'h11, W, 1'b0, 8'h00);
    stop(1);
  endtask

  task automatic test_overrun();
`ifdef SPI_SLAVE_OVR_DET_EN
    @(negedge clk);
    rx_ack[1] = 1'b1;
    @(negedge clk);
    rx_ack[1] = 1'b0;
    n_vec++;
    if (rx_ovr[1] !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_clear_initial: got %b expected 0", rx_ovr[1]);
    end
    start(1);
    run_frame(1, 8'hAB, W, 1'b0, 8'h00);
    run_frame(1, 8'hCD, W, 1'b0, 8'h00);
    stop(1);
    n_vec++;
    if (rx_ovr[1] !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_set: got %b expected 1", rx_ovr[1]);
    end
    @(negedge clk);
    rx_ack[1] = 1'b1;
    @(negedge clk);
    rx_ack[1] = 1'b0;
    n_vec++;
    if (rx_ovr[1] !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_clear: got %b expected 0", rx_ovr[1]);
    end
`else
    n_vec++;
    if (rx_ovr !== 2'b00) begin
      n_err++;
      $display("FAIL ovr_tied: got %b expected 00", rx_ovr);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_cpha1_basic();
    test_cpha0_basic();
    test_back_to_back(1);
    test_back_to_back(0);
    test_abort(1);
    test_abort(0);
    test_empty_hold();
    test_collision();
    test_overrun();
    repeat (2) @(negedge clk);
    n_vec++;
    if (exp_rx0.size() != 0 || exp_rx1.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d/%0d words left, expected 0/0", exp_rx0.size(), exp_rx1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_shifter.md
SPI_SLAVE_SHIFTER -- requirements
Module: spi_slave_shifter

Interface
REQ-001 Parameter DATA_W, default 8: frame length in bits, legal range 4..32.
REQ-002 Parameter CPHA, default 1: selects the SPI clock phase; must match the setting of the upstream SCLK edge stage.
REQ-003 Parameter MSB_FIRST, default 1: 1 shifts MSB first, 0 shifts LSB first, on both MOSI and MISO.
REQ-004 Port clk, input, 1 bit: system clock; the only clock in the block.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port cs_n, input, 1 bit: chip select, active low, already synchronized to clk.
REQ-007 Port sampl_en, input, 1 bit: one-clk pulse telling the block to sample MOSI.
REQ-008 Port shift_en, input, 1 bit: one-clk pulse telling the block to drive the next MISO bit.
REQ-009 Port mosi, input, 1 bit: serial data in.
REQ-010 Port miso, output, 1 bit: serial data out.
REQ-011 Port miso_oe, output, 1 bit: MISO output enable, equal to ~cs_n registered.
REQ-012 Port tx_data, input, DATA_W bits: next word to transmit.
REQ-013 Port tx_valid, input, 1 bit: tx_data is valid.
REQ-014 Port tx_ready, output, 1 bit: the TX holding register is empty.
REQ-015 Port rx_data, output, DATA_W bits: last received word.
REQ-016 Port rx_valid, output, 1 bit: one-clk pulse when rx_data is updated.
REQ-017 Port rx_ovr, output, 1 bit: sticky overrun flag (see REQ-034).

Function
REQ-018 Holding register: accepts tx_data when tx_valid && tx_ready, and becomes full.
REQ-019 tx_ready shall equal ~full.
REQ-020 State machine with states IDLE, ARM, SHIFT.
- IDLE -> ARM when cs_n falls.
- ARM -> SHIFT on the first shift_en (CPHA=1) or immediately (CPHA=0).
- Any state -> IDLE when cs_n = 1.
REQ-021 Frame load: on entering SHIFT (CPHA=0) or on the first shift_en (CPHA=1), tx_shreg shall load the holding register if full, else all-zeros. The holding register shall then empty in the same cycle.
REQ-022 miso shall present the first bit of tx_shreg combinationally from the load cycle onward.
REQ-023 Each subsequent shift_en in SHIFT shall advance tx_shreg by one bit in the MSB_FIRST direction.
REQ-024 Each sampl_en in SHIFT shall shift mosi into rx_shreg and increment bit_cnt, which is clog2(DATA_W)+1 bits wide.
REQ-025 When bit_cnt reaches DATA_W, the block shall in the next clk:
- copy rx_shreg to rx_data;
- pulse rx_valid for 1 clk;
- reset bit_cnt to 0;
- reload tx_shreg per REQ-021 for back-to-back frames without deasserting cs_n.
REQ-026 For CPHA=1 the reload uses the next shift_en; for CPHA=0 it happens in the same cycle as the rx_valid pulse.
REQ-027 Latency: rx_valid asserts exactly 1 clk after the sampl_en that carries the last bit.
REQ-028 Simultaneous tx_valid and frame load in the same clk: the load takes the old holding content, and the new word is accepted into the now-empty holding register; tx_ready stays 0 for that cycle.
REQ-029 sampl_en and shift_en asserted in the same clk (illegal upstream): sampl_en is processed and shift_en is ignored.
REQ-030 cs_n deasserted mid-frame: discard the partial frame, clear bit_cnt, assert no rx_valid, and keep the holding register content.
REQ-031 sampl_en or shift_en while cs_n = 1: ignored.
REQ-032 miso shall be 0 when miso_oe = 0.

Reset
REQ-033 While rst_n = 0, all of the following shall be 0, with state = IDLE and the holding register empty: miso, miso_oe, tx_ready (which rises on the first clk after release), rx_data, rx_valid, rx_ovr, bit_cnt, tx_shreg, rx_shreg.

Configuration
REQ-034 Macro SPI_SLAVE_OVR_DET_EN defined: rx_ovr sets when a frame completes while the previous rx_valid has not been followed by an rx_ack pulse. Input rx_ack (1 bit) exists only in this build. rx_ovr clears on rx_ack.
REQ-035 Macro SPI_SLAVE_OVR_DET_EN undefined: rx_ack is absent, rx_ovr is tied to 0, and no overrun logic is synthesized.

Structure
REQ-036 Shared package spi_pkg shall hold the state enum (IDLE/ARM/SHIFT) and the constant function for the bit_cnt width.
REQ-037 One sub-module, spi_bit_counter, shall hold bit_cnt, the terminal-count compare, and the clear-on-cs_n logic.

Verification
REQ-038 DATA_W=8, CPHA=1, MSB_FIRST=1, tx 0xA5, master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid pulse.
REQ-039 CPHA=0, tx 0x81 loaded before cs_n falls -> miso = 1 before the first sampl_en; rx_valid 1 clk after the 8th sampl_en.
REQ-040 Two back-to-back frames, holding register refilled during frame 1 -> frame 2 transmits the new word with no cs_n toggle; 2 rx_valid pulses.
REQ-041 cs_n raised after 5 bits -> no rx_valid, bit_cnt=0; the next full frame receives correctly.
REQ-042 Holding register empty at load -> miso transmits 0x00; tx_ready stays 1.
REQ-043 SPI_SLAVE_OVR_DET_EN defined, two frames with no rx_ack -> rx_ovr=1 after frame 2; an rx_ack pulse clears it.
